// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one word load/store via valid/ready,
// executes it against an internal word RAM after LATENCY cycles and stalls the pipeline meanwhile.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall_m
);

  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem [Depth];

  logic                    exec;
  logic                    ex_write;
  logic [31:0]             ex_addr;
  logic [31:0]             ex_wdata;
  logic                    ex_err;
  logic [ADDR_WIDTH-1:0]   ex_idx;
  logic                    mem_we;

  // With LATENCY == 1 the access runs on the accept edge, before the request is latched.
  always_comb begin
    if (state_q == StIdle) begin
      ex_write = req_write;
      ex_addr  = req_addr;
      ex_wdata = req_wdata;
    end else begin
      ex_write = write_q;
      ex_addr  = addr_q;
      ex_wdata = wdata_q;
    end
  end

  assign ex_idx = ex_addr[ADDR_WIDTH+1:2];
  assign ex_err = (ex_addr[1:0] != 2'b00) || ((ex_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign mem_we = exec && ex_write && !ex_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = StResp;
            cnt_d   = 4'd0;
            exec    = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          exec    = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (exec) begin
      err_d   = ex_err;
      rdata_d = (ex_err || ex_write) ? 32'd0 : mem[ex_idx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[ex_idx] <= ex_wdata;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign stall_m    = ((state_q == StIdle) && req_valid) || (state_q == StWait);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
